// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access initiator: FSM state
// encoding, opcode values and default geometry of the 11-word byte memory.
package mem_access_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 4;
  localparam int DEPTH_DEF = 11;
  localparam int LW_DEF    = 2;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BEAT  = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_RSP   = 3'd4
  } state_e;

endpackage

// File: rtl/mem_access_master_if.sv
// Host command/write/response channels plus the memory strobe bus, bundled so
// the initiator sees one port and the host/memory side sees the mirror image.
interface mem_access_master_if #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int LW = 2
) ();

  // Every channel uses the same rule: a beat transfers on a rising clk edge
  // where valid & ready are both 1; the sender holds payload stable until then.
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;

  logic          wdata_valid;
  logic          wdata_ready;
  logic [DW-1:0] wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;

  logic          done;
  logic          err;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len,
    input  wdata_valid, wdata,
    input  rsp_ready,
    input  mem_rdata,
    output cmd_ready, wdata_ready,
    output rsp_valid, rsp_data, rsp_last,
    output done, err,
    output mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_len,
    output wdata_valid, wdata,
    output rsp_ready,
    output mem_rdata,
    input  cmd_ready, wdata_ready,
    input  rsp_valid, rsp_data, rsp_last,
    input  done, err,
    input  mem_rd, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_addr_ctr.sv
// Burst address counter that wraps DEPTH-1 -> 0, plus a remaining-beats
// down-counter whose zero state marks the final beat.
module mem_addr_ctr #(
  parameter int AW    = 4,
  parameter int LW    = 2,
  parameter int DEPTH = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [AW-1:0] addr_i,
  input  logic [LW-1:0] len_i,
  input  logic          adv_i,
  output logic [AW-1:0] addr_o,
  output logic [AW-1:0] addr_nxt_o,
  output logic          last_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] beats_q, beats_d;

  assign addr_nxt_o = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
  assign addr_o     = addr_q;
  assign last_o     = (beats_q == '0);

  always_comb begin
    addr_d  = addr_q;
    beats_d = beats_q;
    if (load_i) begin
      addr_d  = addr_i;
      beats_d = len_i;
    end else if (adv_i) begin
      addr_d = addr_nxt_o;
      if (beats_q != '0) beats_d = beats_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      beats_q <= '0;
    end else begin
      addr_q  <= addr_d;
      beats_q <= beats_d;
    end
  end

endmodule

// File: rtl/mem_access_master.sv
// Initiator for the single-port byte memory: turns host read/write bursts into
// registered rd/wr strobes and returns read beats on a back-pressurable port.
module mem_access_master
  import mem_access_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LW    = LW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_master_if.master bus_io,
  output state_e              state_o
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic          mem_rd_q, mem_rd_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_last_q, rsp_last_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          ctr_load, ctr_adv, ctr_last;
  logic [AW-1:0] ctr_addr, ctr_addr_nxt;

  mem_addr_ctr #(.AW(AW), .LW(LW), .DEPTH(DEPTH)) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ctr_load),
    .addr_i     (bus_io.cmd_addr),
    .len_i      (bus_io.cmd_len),
    .adv_i      (ctr_adv),
    .addr_o     (ctr_addr),
    .addr_nxt_o (ctr_addr_nxt),
    .last_o     (ctr_last)
  );

  // Read strobes are raised on the edge entering RD_ISSUE so mem_rd is high
  // for exactly the cycle spent in that state.
  always_comb begin
    state_d     = state_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ctr_load    = 1'b0;
    ctr_adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_io.cmd_valid) begin
          if ({1'b0, bus_io.cmd_addr} >= DEPTH_V) begin
            err_d = 1'b1;
          end else begin
            ctr_load = 1'b1;
            if (bus_io.cmd_op == OP_WR) begin
              state_d = WR_BEAT;
            end else begin
              state_d    = RD_ISSUE;
              mem_rd_d   = 1'b1;
              mem_addr_d = bus_io.cmd_addr;
            end
          end
        end
      end
      WR_BEAT: begin
        if (bus_io.wdata_valid) begin
          mem_wr_d    = 1'b1;
          mem_addr_d  = ctr_addr;
          mem_wdata_d = bus_io.wdata;
          ctr_adv     = 1'b1;
          if (ctr_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        rsp_data_d  = bus_io.mem_rdata;
        rsp_valid_d = 1'b1;
        rsp_last_d  = ctr_last;
        state_d     = RD_RSP;
      end
      RD_RSP: begin
        if (bus_io.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (ctr_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ctr_adv    = 1'b1;
            mem_rd_d   = 1'b1;
            mem_addr_d = ctr_addr_nxt;
            state_d    = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus_io.cmd_ready   = (state_q == IDLE);
  assign bus_io.wdata_ready = (state_q == WR_BEAT);
  assign bus_io.rsp_valid   = rsp_valid_q;
  assign bus_io.rsp_data    = rsp_data_q;
  assign bus_io.rsp_last    = rsp_last_q;
  assign bus_io.done        = done_q;
  assign bus_io.err         = err_q;
  assign bus_io.mem_rd      = mem_rd_q;
  assign bus_io.mem_wr      = mem_wr_q;
  assign bus_io.mem_addr    = mem_addr_q;
  assign bus_io.mem_wdata   = mem_wdata_q;
  assign state_o            = state_q;

endmodule
